// File: rtl/mips_mc_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, state
// encodings, datapath select codes and the packed control vector.
package mips_mc_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  // Every datapath control line driven by the FSM, except pc_en which also
  // needs the ALU zero flag and is formed in the top.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // Successor of DECODE for a given opcode; anything unknown traps to ILLEGAL.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_R_EXEC;
      OP_LW, OP_SW: nxt = S_MEM_ADDR;
      OP_BEQ:       nxt = S_BRANCH;
      OP_ADDI:      nxt = S_ADDI_EXEC;
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure combinational map from controller state to the control vector.
// Unused state encodings fall through to an all-zero vector.
module mips_ctrl_decode
  import mips_mc_controller_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Moore output decode: start from all-zero and raise only what each state needs
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADDI;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit: state register, next-state logic,
// retired-instruction counter and the branch-qualified PC enable.
// Optional single-step gating of FETCH with macro MIPS_MC_STEP_MODE_EN.
module mips_mc_controller
  import mips_mc_controller_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
`ifdef MIPS_MC_STEP_MODE_EN
  input  logic               step,
`endif
  input  logic [5:0]         opcode,
  input  logic               zero,
  output logic               pc_en,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  state_t             state;
  state_t             state_next;
  logic               is_store;
  logic               fetch_hold;
  ctrl_t              dec_ctrl;
  ctrl_t              ctrl;
  logic [COUNT_W-1:0] count_q;

  mips_ctrl_decode u_decode (
    .state (state),
    .ctrl  (dec_ctrl)
  );

`ifdef MIPS_MC_STEP_MODE_EN
  assign fetch_hold = (state == S_FETCH) && !step;
`else
  assign fetch_hold = 1'b0;
`endif

  // Reset and a held FETCH both silence every control line, so no strobe
  // reaches the datapath while an instruction is being abandoned or paused
  always_comb begin
    ctrl = dec_ctrl;
    if (reset || fetch_hold) begin
      ctrl = '0;
    end
  end

  // Next-state selection; opcode is only looked at while in DECODE
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:     state_next = fetch_hold ? S_FETCH : S_DECODE;
      S_DECODE:    state_next = decode_next(opcode);
      S_MEM_ADDR:  state_next = is_store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next = S_MEM_WB;
      S_R_EXEC:    state_next = S_R_WB;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      default:     state_next = S_FETCH;
    endcase
  end

  // State register plus the lw/sw choice captured in DECODE, so later
  // opcode changes cannot redirect MEM_ADDR
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        is_store <= (opcode == OP_SW);
      end
    end
  end

  // Retired-instruction counter, wrapping freely at 2^COUNT_W
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (ctrl.instr_done) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & zero);
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ctrl.illegal_op;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller (COUNT_W=4 so the counter wraps
// quickly). Step-mode vectors are added when MIPS_MC_STEP_MODE_EN is defined.
module tb_mips_mc_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       stepSig = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;

  logic       pc_en, pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] instr_count;

  mips_mc_controller #(.COUNT_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
`ifdef MIPS_MC_STEP_MODE_EN
    .step          (stepSig),
`endif
    .opcode        (opcode),
    .zero          (zero),
    .pc_en         (pc_en),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .instr_count   (instr_count)
  );

  always #5 clock = ~clock;

  // Field order: {pc_en,pc_write,pc_write_cond}_{iord,mem_read,mem_write,ir_write}_
  //              {mem_to_reg,reg_dst,reg_write,alu_src_a}_srcb_aluop_pcsrc_{done,illegal}
  localparam logic [18:0] E_ZERO   = 19'b000_0000_0000_00_00_00_00;
  localparam logic [18:0] E_FETCH  = 19'b110_0101_0000_01_00_00_00;
  localparam logic [18:0] E_DECODE = 19'b000_0000_0000_11_00_00_00;
  localparam logic [18:0] E_MADDR  = 19'b000_0000_0001_10_00_00_00;
  localparam logic [18:0] E_MREAD  = 19'b000_1100_0000_00_00_00_00;
  localparam logic [18:0] E_MWB    = 19'b000_0000_1010_00_00_00_10;
  localparam logic [18:0] E_MWRITE = 19'b000_1010_0000_00_00_00_10;
  localparam logic [18:0] E_REXEC  = 19'b000_0000_0001_00_10_00_00;
  localparam logic [18:0] E_RWB    = 19'b000_0000_0110_00_00_00_10;
  localparam logic [18:0] E_BR_Z1  = 19'b101_0000_0001_00_01_01_10;
  localparam logic [18:0] E_BR_Z0  = 19'b001_0000_0001_00_01_01_10;
  localparam logic [18:0] E_AEXEC  = 19'b000_0000_0001_10_11_00_00;
  localparam logic [18:0] E_AWB    = 19'b000_0000_0010_00_00_00_10;
  localparam logic [18:0] E_JUMP   = 19'b110_0000_0000_00_00_10_10;
  localparam logic [18:0] E_ILL    = 19'b000_0000_0000_00_00_00_01;

  typedef struct {
    string       name;
    logic [18:0] ctl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  int         totalChecks = 0;
  int         passChecks = 0;
  logic [3:0] expCount = 4'd0;

  logic [18:0] actCtl;
  assign actCtl = {pc_en, pc_write, pc_write_cond, iord, mem_read, mem_write,
                   ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                   alu_src_b, alu_op, pc_source, instr_done, illegal_op};

  task automatic checkOutput(input string name, input logic [18:0] act, input logic [18:0] req);
    totalChecks++;
    if (act === req) passChecks++;
    else $display("[TB] FAIL %s: got %b expected %b", name, act, req);
  endtask

  // One cycle of stimulus: drive inputs just after the edge, record the
  // expected outputs for this cycle, then advance the counter model
  task automatic applyStimulus(input string name, input logic rst, input logic [5:0] op,
                               input logic z, input logic st, input logic [18:0] exp);
    exp_t e;
    @(posedge clock);
    #1;
    reset   = rst;
    opcode  = op;
    zero    = z;
    stepSig = st;
    e.name  = name;
    e.ctl   = exp;
    e.cnt   = expCount;
    sb.push_back(e);
    if (rst) expCount = 4'd0;
    else if (exp[1]) expCount = expCount + 4'd1;
  endtask

  // Monitor: every negedge with an entry pending, compare controls and counter
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput({e.name, ".ctl"}, actCtl, e.ctl);
      checkOutput({e.name, ".cnt"}, {15'd0, instr_count}, {15'd0, e.cnt});
    end
  end

  initial begin
    // first edge happens with reset already high
    applyStimulus("rst0", 1'b1, 6'b000000, 1'b0, 1'b1, E_ZERO);
    applyStimulus("rst1", 1'b1, 6'b000000, 1'b0, 1'b1, E_ZERO);

    // lw
    applyStimulus("lw.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
    applyStimulus("lw.decode", 1'b0, 6'b100011, 1'b0, 1'b1, E_DECODE);
    applyStimulus("lw.maddr",  1'b0, 6'b000000, 1'b0, 1'b1, E_MADDR);
    applyStimulus("lw.mread",  1'b0, 6'b000000, 1'b0, 1'b1, E_MREAD);
    applyStimulus("lw.mwb",    1'b0, 6'b000000, 1'b0, 1'b1, E_MWB);

    // sw, with opcode changed to lw after DECODE (must be ignored)
    applyStimulus("sw.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
    applyStimulus("sw.decode", 1'b0, 6'b101011, 1'b0, 1'b1, E_DECODE);
    applyStimulus("sw.maddr",  1'b0, 6'b100011, 1'b0, 1'b1, E_MADDR);
    applyStimulus("sw.mwrite", 1'b0, 6'b100011, 1'b0, 1'b1, E_MWRITE);

    // R-type
    applyStimulus("r.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
    applyStimulus("r.decode", 1'b0, 6'b000000, 1'b0, 1'b1, E_DECODE);
    applyStimulus("r.exec",   1'b0, 6'b000000, 1'b0, 1'b1, E_REXEC);
    applyStimulus("r.wb",     1'b0, 6'b000000, 1'b0, 1'b1, E_RWB);

    // R-type abandoned by reset held two cycles starting in R_WB
    applyStimulus("r2.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
    applyStimulus("r2.decode", 1'b0, 6'b000000, 1'b0, 1'b1, E_DECODE);
    applyStimulus("r2.exec",   1'b0, 6'b000000, 1'b0, 1'b1, E_REXEC);
    applyStimulus("r2.rstwb",  1'b1, 6'b000000, 1'b0, 1'b1, E_ZERO);
    applyStimulus("r2.rst2",   1'b1, 6'b000000, 1'b0, 1'b1, E_ZERO);

    // beq taken, then not taken
    applyStimulus("beq1.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
    applyStimulus("beq1.decode", 1'b0, 6'b000100, 1'b0, 1'b1, E_DECODE);
    applyStimulus("beq1.branch", 1'b0, 6'b000100, 1'b1, 1'b1, E_BR_Z1);
    applyStimulus("beq0.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
    applyStimulus("beq0.decode", 1'b0, 6'b000100, 1'b0, 1'b1, E_DECODE);
    applyStimulus("beq0.branch", 1'b0, 6'b000100, 1'b0, 1'b1, E_BR_Z0);

    // addi
    applyStimulus("addi.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
    applyStimulus("addi.decode", 1'b0, 6'b001000, 1'b0, 1'b1, E_DECODE);
    applyStimulus("addi.exec",   1'b0, 6'b001000, 1'b0, 1'b1, E_AEXEC);
    applyStimulus("addi.wb",     1'b0, 6'b001000, 1'b0, 1'b1, E_AWB);

    // illegal opcode: no retirement
    applyStimulus("ill.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
    applyStimulus("ill.decode", 1'b0, 6'b111111, 1'b0, 1'b1, E_DECODE);
    applyStimulus("ill.trap",   1'b0, 6'b111111, 1'b0, 1'b1, E_ILL);

    // j with a garbage opcode during FETCH
    applyStimulus("j.fetch",  1'b0, 6'b111111, 1'b0, 1'b1, E_FETCH);
    applyStimulus("j.decode", 1'b0, 6'b000010, 1'b0, 1'b1, E_DECODE);
    applyStimulus("j.jump",   1'b0, 6'b000010, 1'b0, 1'b1, E_JUMP);

    // counter wrap: reset, then 16 jumps take the 4-bit count 15 -> 0
    applyStimulus("wrap.rst", 1'b1, 6'b000000, 1'b0, 1'b1, E_ZERO);
    for (int i = 0; i < 16; i++) begin
      applyStimulus("wrap.fetch",  1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);
      applyStimulus("wrap.decode", 1'b0, 6'b000010, 1'b0, 1'b1, E_DECODE);
      applyStimulus("wrap.jump",   1'b0, 6'b000010, 1'b0, 1'b1, E_JUMP);
    end
    applyStimulus("wrap.after", 1'b0, 6'b000000, 1'b0, 1'b1, E_FETCH);

`ifdef MIPS_MC_STEP_MODE_EN
    // paused FETCH, then a single step pulse runs one j
    applyStimulus("step.settle", 1'b0, 6'b000010, 1'b0, 1'b0, E_DECODE);
    applyStimulus("step.jump",   1'b0, 6'b000010, 1'b0, 1'b0, E_JUMP);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("step.hold", 1'b0, 6'b000010, 1'b0, 1'b0, E_ZERO);
    end
    applyStimulus("step.go",     1'b0, 6'b000010, 1'b0, 1'b1, E_FETCH);
    applyStimulus("step.decode", 1'b0, 6'b000010, 1'b0, 1'b0, E_DECODE);
    applyStimulus("step.jump2",  1'b0, 6'b000010, 1'b0, 1'b0, E_JUMP);
    applyStimulus("step.back",   1'b0, 6'b000010, 1'b0, 1'b0, E_ZERO);
`endif

    // let the monitor drain, bounded
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clock);
    #1;
    totalChecks++;
    if (sb.size() == 0) passChecks++;
    else $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
